// File: rtl/ctr_pkg.sv
// Shared CTR protocol definitions used by both the command decoder and the matching encoder.
package ctr_pkg;

    // Decoder state encoding
    typedef logic [2:0] ctr_state_t;

    localparam ctr_state_t ST_IDLE = 3'd0;
    localparam ctr_state_t ST_S1   = 3'd1;
    localparam ctr_state_t ST_S2   = 3'd2;
    localparam ctr_state_t ST_S3   = 3'd3;
    localparam ctr_state_t ST_S4   = 3'd4;
    localparam ctr_state_t ST_GAP  = 3'd5;

    // Two-bit codes carried in the last two bits of the "101xx" extended commands
    localparam logic [1:0] CODE_RES_ROC = 2'b01;
    localparam logic [1:0] CODE_CAL     = 2'b10;
    localparam logic [1:0] CODE_RES_TBM = 2'b11;

    // One bit per decoded-command strobe; at most one is ever set
    typedef struct packed {
        logic trg;
        logic cal;
        logic res_roc;
        logic res_tbm;
        logic err;
    } ctr_strobe_t;

endpackage

// File: rtl/ctr_decoder.sv
// Serial CTR command decoder: samples ctr_in on sync strobes, decodes trg/cal/res_roc/res_tbm,
// flags invalid sequences, and keeps trigger and error counters.
module ctr_decoder
    import ctr_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync,
    input  logic                 enable,
    input  logic                 ctr_in,
    input  logic                 clr_count,
    output logic                 trg,
    output logic                 cal,
    output logic                 res_roc,
    output logic                 res_tbm,
    output logic                 err,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] trg_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    ctr_state_t           state_q, state_d;
    logic                 b3_q, b3_d;
    logic                 zero_cnt_q, zero_cnt_d;
    ctr_strobe_t          strb_q, strb_d;
    ctr_strobe_t          strb_new;
    logic                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0] trg_count_q, trg_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    // Next-state and strobe decode; strobes are renewed on every sync so each lasts one bit period
    always_comb begin
        state_d    = state_q;
        b3_d       = b3_q;
        zero_cnt_d = zero_cnt_q;
        strb_new   = '0;
        strb_d     = strb_q;
        if (!enable) begin
            state_d    = ST_IDLE;
            b3_d       = 1'b0;
            zero_cnt_d = 1'b0;
            strb_d     = '0;
        end else if (sync) begin
            case (state_q)
                ST_IDLE: begin
                    if (ctr_in) begin
                        state_d = ST_S1;
                    end
                end
                ST_S1: begin
                    if (ctr_in) begin
                        strb_new.err = 1'b1;
                        state_d      = ST_GAP;
                        zero_cnt_d   = 1'b0;
                    end else begin
                        state_d = ST_S2;
                    end
                end
                ST_S2: begin
                    if (ctr_in) begin
                        state_d = ST_S3;
                    end else begin
                        strb_new.trg = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
                ST_S3: begin
                    b3_d    = ctr_in;
                    state_d = ST_S4;
                end
                ST_S4: begin
                    case ({b3_q, ctr_in})
                        CODE_RES_ROC: strb_new.res_roc = 1'b1;
                        CODE_CAL:     strb_new.cal     = 1'b1;
                        CODE_RES_TBM: strb_new.res_tbm = 1'b1;
                        default:      strb_new.err     = 1'b1;
                    endcase
                    state_d = ST_IDLE;
                end
                ST_GAP: begin
                    if (ctr_in) begin
                        zero_cnt_d = 1'b0;
                    end else if (zero_cnt_q) begin
                        zero_cnt_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        zero_cnt_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            strb_d = strb_new;
        end
    end

    // Counter updates; clr_count overrides any same-cycle increment or res_tbm clear
    always_comb begin
        trg_count_d = trg_count_q;
        err_count_d = err_count_q;
        busy_d      = (state_d != ST_IDLE);
        if (clr_count) begin
            trg_count_d = '0;
            err_count_d = '0;
        end else begin
            if (strb_new.res_tbm) begin
                trg_count_d = '0;
            end else if (strb_new.trg) begin
                trg_count_d = trg_count_q + CNT_ONE;
            end
            if (strb_new.err && (err_count_q != CNT_MAX)) begin
                err_count_d = err_count_q + CNT_ONE;
            end
        end
    end

    // State, strobe and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            b3_q        <= 1'b0;
            zero_cnt_q  <= 1'b0;
            strb_q      <= '0;
            busy_q      <= 1'b0;
            trg_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            b3_q        <= b3_d;
            zero_cnt_q  <= zero_cnt_d;
            strb_q      <= strb_d;
            busy_q      <= busy_d;
            trg_count_q <= trg_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign trg       = strb_q.trg;
    assign cal       = strb_q.cal;
    assign res_roc   = strb_q.res_roc;
    assign res_tbm   = strb_q.res_tbm;
    assign err       = strb_q.err;
    assign busy      = busy_q;
    assign trg_count = trg_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ctr_decoder.sv
// Testbench for ctr_decoder: directed command sequences plus random traffic, checked against
// a bit-string matching model of the command set.
module tb_ctr_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       sync;
    logic       enable;
    logic       ctr_in;
    logic       clr_count;
    logic       trg, cal, res_roc, res_tbm, err, busy;
    logic [7:0] trg_count, err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits received since the last idle, gap bookkeeping, expected outputs.
    // m_strb order: [4]=trg [3]=cal [2]=res_roc [1]=res_tbm [0]=err
    int         m_buf;
    int         m_len;
    bit         m_gap;
    int         m_zeros;
    logic [4:0] m_strb;
    int         m_trg_cnt;
    int         m_err_cnt;

    // Command table: value (first bit is MSB), length, and which strobe it raises
    int cmd_val[4] = '{4, 21, 22, 23};
    int cmd_len[4] = '{3, 5, 5, 5};
    int cmd_bit[4] = '{4, 2, 3, 1};

    ctr_decoder #(.CNT_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .sync      (sync),
        .enable    (enable),
        .ctr_in    (ctr_in),
        .clr_count (clr_count),
        .trg       (trg),
        .cal       (cal),
        .res_roc   (res_roc),
        .res_tbm   (res_tbm),
        .err       (err),
        .busy      (busy),
        .trg_count (trg_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp_val);
        end
    endtask

    function automatic void modelReset();
        m_buf     = 0;
        m_len     = 0;
        m_gap     = 1'b0;
        m_zeros   = 0;
        m_strb    = '0;
        m_trg_cnt = 0;
        m_err_cnt = 0;
    endfunction

    function automatic void modelDisable();
        m_buf   = 0;
        m_len   = 0;
        m_gap   = 1'b0;
        m_zeros = 0;
        m_strb  = '0;
    endfunction

    // One sampled bit: match against the command table by prefix; a non-prefix is an error
    function automatic void modelSample(input bit b);
        int  hit;
        bit  prefix;
        m_strb = '0;
        if (m_gap) begin
            if (b) begin
                m_zeros = 0;
            end else begin
                m_zeros++;
                if (m_zeros == 2) begin
                    m_gap   = 1'b0;
                    m_zeros = 0;
                end
            end
            return;
        end
        if (m_len == 0 && !b) return;
        m_buf = m_buf * 2 + int'(b);
        m_len++;
        hit    = -1;
        prefix = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_len == cmd_len[i] && m_buf == cmd_val[i]) hit = i;
            if (m_len <= cmd_len[i] && (cmd_val[i] >> (cmd_len[i] - m_len)) == m_buf) prefix = 1'b1;
        end
        if (hit >= 0) begin
            m_strb[cmd_bit[hit]] = 1'b1;
            if (hit == 0) m_trg_cnt = (m_trg_cnt + 1) % 256;
            if (hit == 3) m_trg_cnt = 0;
            m_buf = 0;
            m_len = 0;
        end else if (!prefix) begin
            m_strb[0] = 1'b1;
            m_err_cnt = (m_err_cnt < 255) ? m_err_cnt + 1 : 255;
            m_gap     = (m_len == 2);
            m_zeros   = 0;
            m_buf     = 0;
            m_len     = 0;
        end
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, "_trg"},       32'(trg),       32'(m_strb[4]));
        checkOutput({tag, "_cal"},       32'(cal),       32'(m_strb[3]));
        checkOutput({tag, "_res_roc"},   32'(res_roc),   32'(m_strb[2]));
        checkOutput({tag, "_res_tbm"},   32'(res_tbm),   32'(m_strb[1]));
        checkOutput({tag, "_err"},       32'(err),       32'(m_strb[0]));
        checkOutput({tag, "_busy"},      32'(busy),      32'((m_len > 0) || m_gap));
        checkOutput({tag, "_trg_count"}, 32'(trg_count), 32'(m_trg_cnt));
        checkOutput({tag, "_err_count"}, 32'(err_count), 32'(m_err_cnt));
    endtask

    // One bit period: gap-1 non-sync clocks (ctr_in noise) then the sync clock carrying b
    task automatic applyStimulus(input bit b, input bit clr, input int gap);
        for (int i = 1; i < gap; i++) begin
            sync   = 1'b0;
            ctr_in = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkAll("hold");
        end
        sync      = 1'b1;
        ctr_in    = b;
        clr_count = clr;
        @(posedge clk);
        modelSample(b);
        if (clr) begin
            m_trg_cnt = 0;
            m_err_cnt = 0;
        end
        @(negedge clk);
        sync      = 1'b0;
        clr_count = 1'b0;
        ctr_in    = 1'b0;
        checkAll("sample");
    endtask

    task automatic sendCmd(input int val, input int len, input bit clr_last, input int gap);
        for (int i = len - 1; i >= 0; i--) begin
            applyStimulus(bit'((val >> i) & 1), clr_last && (i == 0), gap);
        end
    endtask

    task automatic dropEnable(input int n);
        enable = 1'b0;
        for (int i = 0; i < n; i++) begin
            sync   = 1'($urandom);
            ctr_in = 1'b1;
            @(posedge clk);
            modelDisable();
            @(negedge clk);
            checkAll("disabled");
        end
        sync   = 1'b0;
        ctr_in = 1'b0;
        enable = 1'b1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        #1;
        modelReset();
        checkAll("reset_async");
        @(posedge clk);
        @(negedge clk);
        checkAll("reset_held");
        reset = 1'b0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pick;
        int gap;
        bit clr;
        reset     = 1'b1;
        sync      = 1'b0;
        enable    = 1'b1;
        ctr_in    = 1'b0;
        clr_count = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAll("por");
        reset = 1'b0;

        // Single trigger, sync every 4th clock
        sendCmd(4, 3, 1'b0, 4);
        checkOutput("trg_count_first", 32'(trg_count), 32'd1);

        // Extended commands back to back; res_tbm clears trg_count
        sendCmd(21, 5, 1'b0, 4);
        sendCmd(22, 5, 1'b0, 4);
        sendCmd(23, 5, 1'b0, 4);
        checkOutput("trg_count_res_tbm", 32'(trg_count), 32'd0);

        // "11" error, gap consumes "01", needs two zeros, then a trigger
        sendCmd(3, 2, 1'b0, 4);
        checkOutput("err_count_gap", 32'(err_count), 32'd1);
        sendCmd(4, 4, 1'b0, 4);
        sendCmd(4, 3, 1'b0, 4);

        // "10100" error, then saturate err_count
        sendCmd(20, 5, 1'b0, 2);
        repeat (256) sendCmd(12, 4, 1'b0, 1);
        checkOutput("err_count_sat", 32'(err_count), 32'd255);
        sendCmd(20, 5, 1'b0, 1);
        checkOutput("err_count_sat_hold", 32'(err_count), 32'd255);

        // clr_count on the same cycle as a trigger wins
        sendCmd(4, 3, 1'b1, 4);
        checkOutput("clr_vs_trg", 32'(trg_count), 32'd0);

        // 256 triggers wrap the counter back to zero
        repeat (256) sendCmd(4, 3, 1'b0, 1);
        checkOutput("trg_wrap", 32'(trg_count), 32'd0);

        // enable dropped after "10", then a normal trigger
        sendCmd(2, 2, 1'b0, 4);
        dropEnable(6);
        checkOutput("busy_after_disable", 32'(busy), 32'd0);
        sendCmd(4, 3, 1'b0, 4);
        checkOutput("trg_after_disable", 32'(trg), 32'd1);

        // reset after "101", then a normal trigger
        sendCmd(5, 3, 1'b0, 4);
        applyReset();
        sendCmd(4, 3, 1'b0, 4);
        checkOutput("trg_after_reset", 32'(trg), 32'd1);

        // Random traffic
        repeat (400) begin
            pick = $urandom_range(0, 7);
            gap  = $urandom_range(1, 4);
            clr  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 24) == 0) dropEnable($urandom_range(1, 3));
            case (pick)
                0, 1, 2, 3: sendCmd(cmd_val[pick], cmd_len[pick], clr, gap);
                4:          sendCmd(12 | $urandom_range(0, 3), 4, clr, gap);
                5:          sendCmd(20, 5, clr, gap);
                6:          applyStimulus(1'b0, clr, gap);
                default:    applyStimulus(1'($urandom), clr, gap);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctr_decoder.md
CTR_DECODER -- requirements
Module: ctr_decoder

Interface
REQ-001 Parameter CNT_WIDTH, default 8, sets the width of the trg_count and err_count outputs.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sync  input  1  bit-period strobe; ctr_in SHALL be sampled only on clk edges where sync=1.
REQ-005 enable  input  1  decoder enable.
REQ-006 ctr_in  input  1  serial command line; idle level is 0.
REQ-007 trg, cal, res_roc, res_tbm  output  1 each  decoded-command strobes.
REQ-008 err  output  1  invalid-sequence strobe.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 trg_count  output  CNT_WIDTH  count of decoded triggers.
REQ-011 err_count  output  CNT_WIDTH  count of decoding errors.
REQ-012 clr_count  input  1  synchronous clear of both counters.

Function
REQ-013 The command set SHALL be: "100" = trg; "10101" = res_roc; "10110" = cal; "10111" = res_tbm. Bits are transmitted first-bit-first, one bit per sync period.
REQ-014 The state machine SHALL have the states IDLE, S1, S2, S3, S4 and GAP, and SHALL change state only on sync cycles.
REQ-015 IDLE: a sampled 1 SHALL move to S1; a sampled 0 SHALL stay in IDLE.
REQ-016 S1: a sampled 0 SHALL move to S2; a sampled 1 SHALL pulse err and move to GAP.
REQ-017 S2: a sampled 0 SHALL pulse trg and move to IDLE; a sampled 1 SHALL move to S3.
REQ-018 S3: the sampled bit SHALL be stored as b3, and the state SHALL move to S4.
REQ-019 S4: the sampled bit b4 SHALL select {b3,b4}: 01 pulses res_roc, 10 pulses cal, 11 pulses res_tbm, 00 pulses err. The state SHALL then move to IDLE.
REQ-020 GAP: the state SHALL move to IDLE only after two consecutive sampled 0s; any sampled 1 SHALL restart the zero count.
REQ-021 Each strobe SHALL be set on the sync cycle that samples the final bit of its command and cleared on the next sync cycle, so it is high for exactly one sync period.
REQ-022 At most one strobe (trg, cal, res_roc, res_tbm, err) SHALL be high at any time.
REQ-023 A new start bit SHALL be accepted on the sync cycle immediately after a command's final bit, with no idle gap required.
REQ-024 While enable=0, the state SHALL be forced to IDLE, all strobes SHALL be 0, ctr_in SHALL be ignored, and the counters SHALL hold.
REQ-025 If enable falls mid-command, the partial command SHALL be discarded without pulsing err.
REQ-026 trg_count SHALL increment by 1 on each trg and wrap from 2^CNT_WIDTH-1 to 0.
REQ-027 trg_count SHALL clear to 0 on res_tbm.
REQ-028 err_count SHALL increment by 1 on each err and saturate at 2^CNT_WIDTH-1.
REQ-029 clr_count=1 on any clk edge SHALL zero both counters, taking priority over a same-cycle increment.
REQ-030 busy SHALL be registered and SHALL reflect the current state.

Reset
REQ-031 On reset, the state SHALL be IDLE, b3=0, the GAP zero count =0, and trg, cal, res_roc, res_tbm, err, busy, trg_count and err_count =0.
REQ-032 Reset asserted mid-command SHALL discard the command with no strobe, and decoding SHALL resume from IDLE on the first sync cycle after release.

Structure
REQ-033 The state encoding and the 2-bit extended command codes (01, 10, 11) SHALL live in the shared CTR package, which the matching encoder also uses.
REQ-034 The block SHALL be a single module with no sub-module; the counters and the state machine SHALL be inline.

Verification
REQ-035 Send "100" with sync every 4th clk -> trg high for one sync period after the 3rd bit; trg_count 0->1.
REQ-036 Send "10101", "10110", "10111" back-to-back with no idle -> res_roc, cal, res_tbm each pulse once, in order, 5 sync periods apart; trg_count is cleared by res_tbm.
REQ-037 Send "11" then "0100" -> err pulses after the 2nd bit; GAP consumes "0" and "1"; the next start bit is recognised only after two 0s; err_count=1.
REQ-038 Send "10100" -> err pulses, no other strobe, err_count=1; with err_count preloaded to 255 via 255 errors, one more error -> err_count stays 255.
REQ-039 Send 256 "100" commands -> trg_count wraps to 0; clr_count pulsed on the same cycle as a trg -> trg_count=0.
REQ-040 Drop enable after "10" and assert reset after "101" in separate runs -> no strobes, busy=0, and a following "100" decodes normally.
